// File: rtl/imem_sync.sv
// Instruction memory with single-cycle synchronous fetch and a byte-serial loader.
// FETCH serves one read per cycle; LOAD assembles little-endian words from a byte
// stream and writes them at an auto-incrementing word pointer.
module imem_sync #(
    parameter int unsigned IMEM_W    = 13,
    parameter bit          BOOT_LOAD = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [IMEM_W-1:0] i_addr,
    output logic [31:0]       o_rdata,
    output logic              o_rvalid,
    output logic              o_misalign,
    input  logic              i_ld_start,
    input  logic              i_ld_valid,
    input  logic [7:0]        i_ld_byte,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic              o_ld_busy,
    output logic [IMEM_W-2:0] o_ld_words
);

    localparam int unsigned PTR_W = IMEM_W - 2;
    localparam int unsigned DEPTH = 2 ** PTR_W;

    typedef enum logic {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } state_t;

    localparam state_t RST_STATE = BOOT_LOAD ? LOAD : FETCH;

    state_t           state;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] ld_ptr;
    logic [1:0]       ld_idx;
    logic [23:0]      ld_buf;

    logic             fetch_acc_c;
    logic             ld_acc_c;
    logic             wr_en_c;
    logic             ld_done_c;
    logic [31:0]      wr_data_c;

    // Accept/complete decode for fetch and load paths; the buffer holds bytes 0..2
    // so unreceived upper bytes of a partial word are always zero.
    always_comb begin
        fetch_acc_c = 1'b0;
        ld_acc_c    = 1'b0;
        wr_en_c     = 1'b0;
        ld_done_c   = 1'b0;
        wr_data_c   = {8'h00, ld_buf} | (32'(i_ld_byte) << {ld_idx, 3'b000});
        fetch_acc_c = (state == FETCH) && i_req;
        ld_acc_c    = (state == LOAD) && i_ld_valid && !i_ld_start;
        wr_en_c     = ld_acc_c && (i_ld_last || (ld_idx == 2'd3));
        ld_done_c   = ld_acc_c &&
                      (i_ld_last || ((ld_idx == 2'd3) && (ld_ptr == PTR_W'(DEPTH - 1))));
    end

    // Control FSM, load pointer/assembly state and registered read port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= RST_STATE;
            o_ld_busy  <= BOOT_LOAD;
            o_ld_ready <= BOOT_LOAD;
            ld_ptr     <= '0;
            ld_idx     <= '0;
            ld_buf     <= '0;
            o_ld_words <= '0;
            o_rvalid   <= 1'b0;
            o_misalign <= 1'b0;
            o_rdata    <= '0;
        end else begin
            o_rvalid   <= fetch_acc_c;
            o_misalign <= fetch_acc_c && (i_addr[1:0] != 2'b00);
            if (fetch_acc_c) begin
                o_rdata <= mem[i_addr[IMEM_W-1:2]];
            end

            case (state)
                FETCH: begin
                    if (i_ld_start) begin
                        state      <= LOAD;
                        o_ld_busy  <= 1'b1;
                        o_ld_ready <= 1'b1;
                        ld_ptr     <= '0;
                        ld_idx     <= '0;
                        ld_buf     <= '0;
                        o_ld_words <= '0;
                    end
                end
                LOAD: begin
                    if (i_ld_start) begin
                        ld_ptr     <= '0;
                        ld_idx     <= '0;
                        ld_buf     <= '0;
                        o_ld_words <= '0;
                    end else if (ld_acc_c) begin
                        if (wr_en_c) begin
                            ld_ptr     <= ld_ptr + 1'b1;
                            ld_idx     <= '0;
                            ld_buf     <= '0;
                            o_ld_words <= o_ld_words + 1'b1;
                        end else begin
                            ld_idx <= ld_idx + 1'b1;
                            ld_buf <= wr_data_c[23:0];
                        end
                        if (ld_done_c) begin
                            state      <= FETCH;
                            o_ld_busy  <= 1'b0;
                            o_ld_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Word array write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem[ld_ptr] <= wr_data_c;
        end
    end

endmodule

// File: tb/tb_imem_sync.sv
// Randomised scoreboard bench for imem_sync (small memory so the full-load
// boundary is reachable).
module tb_imem_sync;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 64;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   o_rdata;
    logic          o_rvalid;
    logic          o_misalign;
    logic          i_ld_start = 1'b0;
    logic          i_ld_valid = 1'b0;
    logic [7:0]    i_ld_byte = '0;
    logic          i_ld_last = 1'b0;
    logic          o_ld_ready;
    logic          o_ld_busy;
    logic [AW-2:0] o_ld_words;

    imem_sync #(.IMEM_W(AW), .BOOT_LOAD(1'b0)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .o_rdata    (o_rdata),
        .o_rvalid   (o_rvalid),
        .o_misalign (o_misalign),
        .i_ld_start (i_ld_start),
        .i_ld_valid (i_ld_valid),
        .i_ld_byte  (i_ld_byte),
        .i_ld_last  (i_ld_last),
        .o_ld_ready (o_ld_ready),
        .o_ld_busy  (o_ld_busy),
        .o_ld_words (o_ld_words)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] last_data = '0;
    bit          in_load = 1'b0;

    always @(posedge i_clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard when a response is due, otherwise checks idle/hold.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            last_data = '0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rvalid", 32'(o_rvalid), 32'd1);
            chk("rdata", o_rdata, e.data);
            chk("misalign", 32'(o_misalign), 32'(e.mis));
            last_data = e.data;
        end else begin
            chk("rvalid_idle", 32'(o_rvalid), 32'd0);
            chk("misalign_idle", 32'(o_misalign), 32'd0);
            chk("rdata_hold", o_rdata, last_data);
        end
    end

    // Reference: a load from pointer 0 commits whole words, plus the partial
    // word (zero-filled) only when the stream is closed with last.
    function automatic int mdl_load(input logic [7:0] b[$], input bit last);
        int n = b.size();
        int nw = last ? (n + 3) / 4 : n / 4;
        if (nw > DEPTH) nw = DEPTH;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word = '0;
            for (int k = 0; k < 4; k++)
                if (w * 4 + k < n) word = word | (32'(b[w*4+k]) << (8 * k));
            mdl[w] = word;
        end
        return nw;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        i_req  = 1'b1;
        i_addr = a;
        if (!in_load) q.push_back('{cyc + 1, mdl[a[AW-1:2]], a[1:0] != 2'b00});
        step();
        i_req = 1'b0;
    endtask

    task automatic ld_start();
        i_ld_start = 1'b1;
        i_ld_valid = 1'($urandom_range(0, 1));
        i_ld_byte  = 8'($urandom);
        step();
        i_ld_start = 1'b0;
        i_ld_valid = 1'b0;
        in_load    = 1'b1;
        chk("start_busy", 32'(o_ld_busy), 32'd1);
        chk("start_ready", 32'(o_ld_ready), 32'd1);
        chk("start_words", 32'(o_ld_words), 32'd0);
    endtask

    // Byte stream with random idle gaps; fetch requests are thrown in and must be ignored.
    task automatic send(input logic [7:0] b[$], input bit last);
        for (int i = 0; i < b.size(); i++) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                i_ld_valid = 1'b0;
                i_req      = 1'($urandom_range(0, 1));
                i_addr     = AW'($urandom);
                step();
            end
            chk("ld_ready", 32'(o_ld_ready), 32'd1);
            i_ld_valid = 1'b1;
            i_ld_byte  = b[i];
            i_ld_last  = last && (i == b.size() - 1);
            i_req      = 1'($urandom_range(0, 1));
            i_addr     = AW'($urandom);
            step();
        end
        i_ld_valid = 1'b0;
        i_ld_last  = 1'b0;
        i_req      = 1'b0;
    endtask

    task automatic ld_status(input string name, input int words, input bit busy);
        chk({name, "_words"}, 32'(o_ld_words), 32'(words));
        chk({name, "_busy"}, 32'(o_ld_busy), 32'(busy));
        in_load = busy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b[$];
        logic [7:0] b2[$];
        int nw;

        // Reset values
        #2 i_rst_n = 1'b0;
        #20;
        chk("rst_rvalid", 32'(o_rvalid), 32'd0);
        chk("rst_misalign", 32'(o_misalign), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_busy", 32'(o_ld_busy), 32'd0);
        chk("rst_ready", 32'(o_ld_ready), 32'd0);
        chk("rst_words", 32'(o_ld_words), 32'd0);
        step();
        i_rst_n = 1'b1;
        step();

        // Two-word program load, then fetches
        ld_start();
        b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        nw = mdl_load(b, 1'b1);
        send(b, 1'b1);
        ld_status("prog", nw, 1'b0);
        chk("prog_w0_model", mdl[0], 32'h0000_0013);
        fetch(8'h00);
        fetch(8'h04);
        step();
        fetch(8'h06);
        step();

        // Bytes offered in FETCH are dropped
        for (int i = 0; i < 3; i++) begin
            i_ld_valid = 1'b1;
            i_ld_byte  = 8'($urandom);
            i_ld_last  = 1'($urandom_range(0, 1));
            step();
            chk("fetch_ready", 32'(o_ld_ready), 32'd0);
            chk("fetch_words", 32'(o_ld_words), 32'd2);
        end
        i_ld_valid = 1'b0;
        i_ld_last  = 1'b0;
        fetch(8'h00);
        fetch(8'h04);
        step();

        // Random loads followed by random fetches, incl. back-to-back 0,4,8
        for (int it = 0; it < 4; it++) begin
            int n = $urandom_range(12, 40);
            b.delete();
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            ld_start();
            nw = mdl_load(b, 1'b1);
            send(b, 1'b1);
            ld_status("rand", nw, 1'b0);
            fetch(8'h00);
            fetch(8'h04);
            fetch(8'h08);
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(0, 2) == 0) step();
                fetch(AW'({$urandom_range(0, nw - 1), 2'($urandom)}));
            end
            step();
        end

        // Two-byte load closed by last
        ld_start();
        b = '{8'hAA, 8'hBB};
        nw = mdl_load(b, 1'b1);
        send(b, 1'b1);
        ld_status("short", 1, 1'b0);
        chk("short_w0_model", mdl[0], 32'h0000_BBAA);
        fetch(8'h00);
        fetch(8'h05);
        step();

        // Fetch on the LOAD-entry cycle, restart mid-word, then 01..04 + partial 55
        i_req      = 1'b1;
        i_addr     = 8'h00;
        i_ld_start = 1'b1;
        q.push_back('{cyc + 1, mdl[0], 1'b0});
        step();
        i_req      = 1'b0;
        i_ld_start = 1'b0;
        in_load    = 1'b1;
        chk("entry_busy", 32'(o_ld_busy), 32'd1);
        b = '{8'hDE, 8'hAD, 8'hBE};
        send(b, 1'b0);
        ld_start();
        b  = '{8'h01, 8'h02, 8'h03, 8'h04};
        b2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55};
        nw = mdl_load(b2, 1'b1);
        send(b, 1'b0);
        ld_status("restart", 1, 1'b1);
        b = '{8'h55};
        send(b, 1'b1);
        ld_status("restart_end", nw, 1'b0);
        chk("restart_w0_model", mdl[0], 32'h0403_0201);
        fetch(8'h00);
        fetch(8'h04);
        step();

        // Fill the whole memory without last: ends on the final byte
        b.delete();
        for (int i = 0; i < DEPTH * 4; i++) b.push_back(8'($urandom));
        ld_start();
        nw = mdl_load(b, 1'b0);
        b2 = b[0:DEPTH*4-2];
        send(b2, 1'b0);
        ld_status("full_pre", DEPTH - 1, 1'b1);
        b2 = '{b[DEPTH*4-1]};
        send(b2, 1'b0);
        ld_status("full", nw, 1'b0);
        fetch(AW'((DEPTH - 1) * 4));
        fetch(8'h00);
        for (int k = 0; k < 10; k++) fetch(AW'($urandom));
        step();

        // Reset in the middle of the second word
        ld_start();
        b.delete();
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        nw = mdl_load(b, 1'b0);
        send(b, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(o_ld_busy), 32'd0);
        chk("mid_rst_words", 32'(o_ld_words), 32'd0);
        chk("mid_rst_rdata", o_rdata, 32'd0);
        in_load = 1'b0;
        step();
        i_rst_n = 1'b1;
        fetch(8'h00);
        fetch(8'h04);
        fetch(AW'((DEPTH - 1) * 4));
        step();
        step();
        step();

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 SHALL have parameter IMEM_W, default 13, byte-address width; depth = 2**(IMEM_W-2) 32-bit words.
REQ-002 SHALL have parameter BOOT_LOAD, default 0; when 1, the block leaves reset in LOAD state instead of FETCH.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_req  input  1  fetch request.
REQ-006 SHALL have port i_addr  input  IMEM_W  fetch byte address.
REQ-007 SHALL have port o_rdata  output  32  fetched word, little-endian.
REQ-008 SHALL have port o_rvalid  output  1  o_rdata valid, one-cycle pulse per accepted request.
REQ-009 SHALL have port o_misalign  output  1  accepted request had i_addr[1:0] != 0, aligned with o_rvalid.
REQ-010 SHALL have port i_ld_start  input  1  enter LOAD, clear load pointer.
REQ-011 SHALL have port i_ld_valid  input  1  load byte present.
REQ-012 SHALL have port i_ld_byte  input  8  load byte.
REQ-013 SHALL have port i_ld_last  input  1  qualifies final byte, sampled with i_ld_valid.
REQ-014 SHALL have port o_ld_ready  output  1  load byte accepted this cycle when high with i_ld_valid.
REQ-015 SHALL have port o_ld_busy  output  1  high in LOAD state.
REQ-016 SHALL have port o_ld_words  output  IMEM_W-1  words written since last i_ld_start.

Function
REQ-017 SHALL implement states FETCH and LOAD; FETCH->LOAD on i_ld_start; LOAD->FETCH on the cycle that accepts a byte with i_ld_last=1 or the byte completing the last word (pointer at depth-1, byte 3).
REQ-018 In FETCH, i_req=1 SHALL be accepted every cycle; read is synchronous: o_rdata/o_rvalid appear exactly 1 cycle after acceptance.
REQ-019 Fetch SHALL index word i_addr[IMEM_W-1:2]; i_addr[1:0] ignored for data, reported on o_misalign.
REQ-020 o_rdata SHALL hold its last value when no request is accepted; o_rvalid SHALL be 0 then.
REQ-021 In LOAD, i_req SHALL be ignored (o_rvalid=0); o_ld_ready=1 every LOAD cycle.
REQ-022 Load bytes SHALL assemble little-endian: byte 0 -> [7:0] ... byte 3 -> [31:24]; word written at pointer on acceptance of byte 3, pointer then increments.
REQ-023 If i_ld_last arrives on byte k<3, the partial word SHALL be written with unreceived bytes zero, pointer incremented, o_ld_words incremented.
REQ-024 o_ld_words SHALL increment once per word written, saturating is not needed (max = depth).
REQ-025 i_ld_start during LOAD SHALL restart: pointer, byte index, o_ld_words cleared; partial word discarded; i_ld_start wins over a simultaneous i_ld_valid.
REQ-026 A fetch accepted the cycle before LOAD entry SHALL still return o_rvalid the next cycle.
REQ-027 A fetch to a word written in the same cycle SHALL not occur (fetch disabled in LOAD); the first fetch after LOAD returns new contents.
REQ-028 Memory contents SHALL be unaffected by reset; content undefined until loaded (simulation may preinitialise).
REQ-029 o_ld_ready SHALL be 0 in FETCH; bytes offered then are dropped.

Reset
REQ-030 On i_rst_n=0, asynchronously: state=FETCH (LOAD if BOOT_LOAD=1), o_rvalid=0, o_misalign=0, o_rdata=0, pointer=0, byte index=0, o_ld_words=0, o_ld_busy per state.
REQ-031 Reset mid-load SHALL discard the partial word; already-written words SHALL remain.
REQ-032 After deassertion, the first rising edge SHALL accept requests normally.

Verification
REQ-033 Load bytes 13,00,00,00,93,00,10,00 (last on 8th) -> o_ld_words=2, then fetch 0x0 -> 0x00000013, fetch 0x4 -> 0x00100093, each o_rvalid 1 cycle after i_req.
REQ-034 Back-to-back fetch 0x0,0x4,0x8 on consecutive cycles -> three consecutive o_rvalid pulses with matching words.
REQ-035 Fetch 0x6 -> word at 0x4 returned with o_misalign=1.
REQ-036 Load AA,BB with i_ld_last on BB -> word 0 = 0x0000BBAA, o_ld_words=1, state returns FETCH.
REQ-037 Load 3 bytes, pulse i_ld_start, load 4 bytes 01,02,03,04 -> word 0 = 0x04030201, o_ld_words counts from 0.
REQ-038 Assert i_rst_n=0 mid-word during load -> o_ld_busy=0, o_ld_words=0 immediately; previously completed words still read correctly.
